// File: rtl/adder_bist.sv
// Built-in self-test sequencer: sweeps every a/b/cin combination through an external adder and
// checks each result against an internal reference. Define ADDER_BIST_STOP_ON_FAIL_EN to halt on the first mismatch.
module adder_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 cin_out,
    input  logic [WIDTH-1:0]     s_in,
    input  logic                 cout_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail
);

    localparam int VW = 2 * WIDTH + 1;
    localparam int EW = 2 * WIDTH + 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    logic [1:0]    state_q,   state_d;
    logic [VW-1:0] vec_q,     vec_d;
    logic [3:0]    cnt_q,     cnt_d;
    logic [EW-1:0] err_q,     err_d;
    logic [VW-1:0] first_q,   first_d;
    logic          seen_q,    seen_d;

    logic [WIDTH:0] ref_sum;
    logic           mismatch;

    // Zero-extended reference so the carry lands in the top bit.
    assign ref_sum  = {1'b0, vec_q[2*WIDTH-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]}
                    + {{WIDTH{1'b0}}, vec_q[VW-1]};
    assign mismatch = ({cout_in, s_in} != ref_sum);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        seen_d  = seen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!seen_q) begin
                        first_d = vec_q;
                        seen_d  = 1'b1;
                    end
                end
                if ((mismatch && STOP_ON_FAIL) || (&vec_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                    vec_d   = vec_q + VW'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            seen_q  <= seen_d;
        end
    end

    assign cin_out    = vec_q[VW-1];
    assign a_out      = vec_q[2*WIDTH-1:WIDTH];
    assign b_out      = vec_q[WIDTH-1:0];
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = first_q;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: table of full sweeps against ideal and faulty adder models,
// plus hand-written reset, busy-start and restart sequences.
module tb_adder_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a_out, b_out, s_in;
    logic       cin_out, cout_in;
    logic       busy, done, pass;
    logic [9:0] err_count;
    logic [8:0] first_fail;

    int fault;  // 0 ideal, 1 s[0] stuck at 0, 2 cout stuck at 0
    int n_checks = 0;
    int n_fail   = 0;

    adder_bist dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .cin_out    (cin_out),
        .s_in       (s_in),
        .cout_in    (cout_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    logic [4:0] sum;
    always_comb begin
        sum     = 5'(a_out) + 5'(b_out) + 5'(cin_out);
        s_in    = sum[3:0];
        cout_in = sum[4];
        if (fault == 1) s_in[0] = 1'b0;
        if (fault == 2) cout_in = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_sweep(input int ignore_at, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        cycles = 0;
        while (!done && cycles < 4000) begin
            if (cycles == ignore_at) begin
                @(negedge clk);
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
    endtask

    typedef struct {
        int         fault;
        int         cycles;
        logic       pass;
        logic [9:0] err;
        logic [8:0] first;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
    } vec_t;

    vec_t tbl[3];
    int   cyc;

    initial begin
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        tbl[0] = '{0, 1536, 1'b1, 10'd0, 9'd0,  4'd15, 4'd15, 1'b1};
        tbl[1] = '{1, 6,    1'b0, 10'd1, 9'd1,  4'd0,  4'd1,  1'b0};
        tbl[2] = '{2, 96,   1'b0, 10'd1, 9'd31, 4'd1,  4'd15, 1'b0};
`else
        tbl[0] = '{0, 1536, 1'b1, 10'd0,   9'd0,  4'd15, 4'd15, 1'b1};
        tbl[1] = '{1, 1536, 1'b0, 10'd256, 9'd1,  4'd15, 4'd15, 1'b1};
        tbl[2] = '{2, 1536, 1'b0, 10'd256, 9'd31, 4'd15, 4'd15, 1'b1};
`endif
        fault = 0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_fail, 0);
        check("rst_vec", {cin_out, a_out, b_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            fault = tbl[i].fault;
            run_sweep(-1, cyc);
            check($sformatf("t%0d_cycles", i), cyc, tbl[i].cycles);
            check($sformatf("t%0d_busy", i), busy, 0);
            check($sformatf("t%0d_pass", i), pass, tbl[i].pass);
            check($sformatf("t%0d_err", i), err_count, tbl[i].err);
            check($sformatf("t%0d_first", i), first_fail, tbl[i].first);
            check($sformatf("t%0d_a", i), a_out, tbl[i].a);
            check($sformatf("t%0d_b", i), b_out, tbl[i].b);
            check($sformatf("t%0d_cin", i), cin_out, tbl[i].cin);
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("t%0d_done_held", i), done, 1);
        end

        // Restart from DONE with an ideal adder: results cleared on the start edge.
        fault = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_done_low", done, 0);
        check("restart_err_clr", err_count, 0);
        check("restart_first_clr", first_fail, 0);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("restart_cycles", cyc, 1536);
        check("restart_pass", pass, 1);

        // A start pulse while busy must not extend or restart the sweep.
        run_sweep(10, cyc);
        check("busy_start_cycles", cyc, 1536);
        check("busy_start_pass", pass, 1);

        // Asynchronous reset mid-sweep with a faulty adder.
        fault = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (699) @(posedge clk);
        #1;
        check("pre_rst_err_nz", (err_count != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_first", first_fail, 0);
        check("mid_rst_vec", {cin_out, a_out, b_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bist.md
# adder_bist

Built-in self-test sequencer for the 4-bit ripple-carry adder. It drives the adder's a/b/cin inputs and reads back s/cout, sweeping all 2^(2·WIDTH+1) input combinations. Each result is checked against an internally computed reference sum. The block reports pass/fail, a mismatch count and the first failing vector, so the adder is verified on hardware without a simulator.

## Interface
- WIDTH, 4: operand width; must match the adder under test.
- SETTLE, 2: cycles the adder inputs are held stable before the result is sampled; legal range 1..15.
- clk  input  1: single clock; all state updates on its rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- start  input  1: one-cycle pulse; begins a sweep when sampled in IDLE or DONE.
- a_out  output  WIDTH: operand A to the adder.
- b_out  output  WIDTH: operand B to the adder.
- cin_out  output  1: carry-in to the adder.
- s_in  input  WIDTH: sum from the adder.
- cout_in  input  1: carry-out from the adder.
- busy  output  1: high while a sweep is running.
- done  output  1: high in DONE; held until the next start or reset.
- pass  output  1: valid when done=1; 1 iff err_count==0.
- err_count  output  2·WIDTH+2: number of mismatching vectors; cannot overflow.
- first_fail  output  2·WIDTH+1: vector index of the first mismatch; 0 if none.

## Operation
- Vector index v has width 2·WIDTH+1.
  - cin_out = v[2W], a_out = v[2W-1:W], b_out = v[W-1:0].
  - All three are registered directly from v.
- Reference sum: {cout,s} = a_out + b_out + cin_out, computed at WIDTH+1 bits with zero extension. A mismatch is {cout_in,s_in} ≠ reference.
- States:
  - IDLE: busy=0, done=0.
    - start → v=0, settle counter=0, err_count=0, first_fail=0, fail-seen flag=0, go to SETTLE.
  - SETTLE: busy=1.
    - Settle counter increments each cycle.
    - When the counter reaches SETTLE-1, go to CHECK.
  - CHECK: busy=1. The comparison is evaluated on this cycle's edge.
    - On mismatch: err_count+1. If the fail-seen flag is clear, first_fail=v and the flag is set.
    - If v is all-ones: go to DONE.
    - Otherwise: v+1, settle counter=0, go to SETTLE.
  - DONE: busy=0, done=1; pass = (err_count==0).
    - a_out, b_out and cin_out hold the last vector.
    - start → same actions as start in IDLE.
- start while busy=1 is ignored.
- rst_n low at any time, including mid-sweep, immediately returns to IDLE with all outputs at their reset values.
- The sweep restarts only on a new start.

## Timing
- Reset values: a_out=0, b_out=0, cin_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, state IDLE.
- Per vector: SETTLE+1 cycles (SETTLE in SETTLE state, 1 in CHECK).
- Start to done: busy rises on the edge that samples start. done rises (SETTLE+1)·2^(2W+1) edges later.
  - Defaults: 3·512 = 1536 cycles.
- err_count and first_fail update on the CHECK edge. done and pass are valid from the edge that enters DONE.
- The adder sees each vector for SETTLE+1 full cycles before the following vector is driven.

## Configuration
- ADDER_BIST_STOP_ON_FAIL_EN defined:
  - The first mismatch in CHECK goes straight to DONE.
  - err_count=1, first_fail=v; a_out, b_out and cin_out hold the failing vector for probing.
- Not defined: the full sweep always completes and err_count holds the total number of mismatches.

## Test plan
- Ideal adder model, defaults, start pulse → done exactly 1536 cycles later; pass=1, err_count=0, first_fail=0.
- Adder with s[0] stuck at 0, macro off → pass=0, err_count=256, first_fail=1 (a=0, b=1, cin=0).
- Adder with cout stuck at 0, macro off → err_count=256, first_fail=31 (a=1, b=15, cin=0).
- s[0] stuck at 0, macro on → done 6 cycles after start; err_count=1, first_fail=1; a_out=0, b_out=1, cin_out=0 held.
- rst_n low at cycle 700 of a sweep → all outputs return to reset values immediately. A start pulse during busy is ignored. A start from DONE reruns the sweep and clears err_count.
